// File: rtl/ssp_tx_serializer.sv
// TI-style SSP transmit serializer: pops words from the TX FIFO and shifts them
// out MSB-first with a one-slot frame pulse, SSPCLKOUT = PCLK/2.
module ssp_tx_serializer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  PCLK,
  input  logic                  CLEAR,
  input  logic                  SSE,
  input  logic                  ValidWord,
  input  logic [DATA_WIDTH-1:0] TxData,
  output logic                  NextWord,
  output logic                  SSPCLKOUT,
  output logic                  SSPFSSOUT,
  output logic                  SSPTXD,
  output logic                  SSPOE_B,
  output logic                  BUSY
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  phase_q, phase_d;

  logic clk_q, clk_d;
  logic fss_q, fss_d;
  logic txd_q, txd_d;
  logic oeb_q, oeb_d;
  logic busy_q, busy_d;

  logic load_slot;

  // A new word may be accepted when idle or at the very end of the last bit slot.
  assign load_slot = (state_q == ST_IDLE) ||
                     ((state_q == ST_SHIFT) && (cnt_q == '0) && phase_q);
  assign NextWord  = !CLEAR && ValidWord && SSE && load_slot;

  // Next-state logic; registered outputs are decoded from the next state so
  // they line up with the cycle the state becomes active.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;

    unique case (state_q)
      ST_IDLE: begin
        if (NextWord) begin
          state_d = ST_FRAME;
          shift_d = TxData;
          phase_d = 1'b0;
        end
      end
      ST_FRAME: begin
        phase_d = !phase_q;
        if (phase_q) begin
          state_d = ST_SHIFT;
          cnt_d   = CNT_W'(DATA_WIDTH - 1);
        end
      end
      ST_SHIFT: begin
        phase_d = !phase_q;
        if (phase_q) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (NextWord) begin
            state_d = ST_FRAME;
            shift_d = TxData;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = 1'b0;
      end
    endcase

    clk_d  = (state_d != ST_IDLE) && !phase_d;
    fss_d  = (state_d == ST_FRAME);
    txd_d  = (state_d == ST_SHIFT) ? shift_d[cnt_d] : 1'b0;
    oeb_d  = (state_d == ST_IDLE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      clk_q   <= 1'b0;
      fss_q   <= 1'b0;
      txd_q   <= 1'b0;
      oeb_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      clk_q   <= clk_d;
      fss_q   <= fss_d;
      txd_q   <= txd_d;
      oeb_q   <= oeb_d;
      busy_q  <= busy_d;
    end
  end

  assign SSPCLKOUT = clk_q;
  assign SSPFSSOUT = fss_q;
  assign SSPTXD    = txd_q;
  assign SSPOE_B   = oeb_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_ssp_tx_serializer.sv
// Bench for ssp_tx_serializer: frame-position reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_ssp_tx_serializer;

  localparam int unsigned W      = 8;
  localparam int          FLEN   = 2 * W + 2;

  logic         PCLK = 1'b0;
  logic         CLEAR;
  logic         SSE;
  logic         ValidWord;
  logic [W-1:0] TxData;
  logic         NextWord;
  logic         SSPCLKOUT;
  logic         SSPFSSOUT;
  logic         SSPTXD;
  logic         SSPOE_B;
  logic         BUSY;

  ssp_tx_serializer #(.DATA_WIDTH(W)) dut (
    .PCLK      (PCLK),
    .CLEAR     (CLEAR),
    .SSE       (SSE),
    .ValidWord (ValidWord),
    .TxData    (TxData),
    .NextWord  (NextWord),
    .SSPCLKOUT (SSPCLKOUT),
    .SSPFSSOUT (SSPFSSOUT),
    .SSPTXD    (SSPTXD),
    .SSPOE_B   (SSPOE_B),
    .BUSY      (BUSY)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
  endtask

  // Reference model: a frame is just a position k = 1..FLEN after its load edge.
  bit         m_active = 1'b0;
  int         m_k      = 0;
  logic [W-1:0] m_word = '0;

  function automatic logic exp_nw();
    return !CLEAR && ValidWord && SSE && (!m_active || m_k == FLEN);
  endfunction
  function automatic logic exp_clk();
    return m_active && (m_k % 2 == 1);
  endfunction
  function automatic logic exp_fss();
    return m_active && (m_k <= 2);
  endfunction
  function automatic logic exp_txd();
    if (!m_active || m_k < 3) return 1'b0;
    return m_word[W - 1 - (m_k - 3) / 2];
  endfunction

  always @(posedge PCLK) begin
    if (CLEAR) begin
      m_active = 1'b0;
    end else if (exp_nw()) begin
      m_active = 1'b1;
      m_k      = 1;
      m_word   = TxData;
    end else if (m_active && m_k == FLEN) begin
      m_active = 1'b0;
    end else if (m_active) begin
      m_k++;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge PCLK) begin
    if (chk_en) begin
      chk("NextWord",  32'(NextWord),  32'(exp_nw()));
      chk("SSPCLKOUT", 32'(SSPCLKOUT), 32'(exp_clk()));
      chk("SSPFSSOUT", 32'(SSPFSSOUT), 32'(exp_fss()));
      chk("SSPTXD",    32'(SSPTXD),    32'(exp_txd()));
      chk("SSPOE_B",   32'(SSPOE_B),   32'(!m_active));
      chk("BUSY",      32'(BUSY),      32'(m_active));
    end
  end

  // FIFO stand-in and directed-test bookkeeping.
  logic [W-1:0] fifo[$];
  bit           valid_gate = 1'b0;
  int           rel = 0;
  int           nw_cyc[$];
  logic [63:0]  cap_clk, cap_fss, cap_txd, cap_oeb, cap_busy, mdl_txd;

  task automatic drive();
    ValidWord = valid_gate && (fifo.size() > 0);
    TxData    = (fifo.size() > 0) ? fifo[0] : W'($urandom);
  endtask

  task automatic tick();
    logic nw_s;
    @(negedge PCLK);
    nw_s = NextWord;
    @(posedge PCLK);
    #1;
    if (nw_s) begin
      nw_cyc.push_back(rel);
      if (fifo.size() > 0) void'(fifo.pop_front());
    end
    rel++;
    drive();
    if (rel < 64) begin
      cap_clk[rel]  = SSPCLKOUT;
      cap_fss[rel]  = SSPFSSOUT;
      cap_txd[rel]  = SSPTXD;
      cap_oeb[rel]  = SSPOE_B;
      cap_busy[rel] = BUSY;
      mdl_txd[rel]  = exp_txd();
    end
  endtask

  task automatic start_test();
    rel = 0;
    nw_cyc.delete();
    cap_clk = '0; cap_fss = '0; cap_txd = '0; cap_oeb = '0; cap_busy = '0; mdl_txd = '0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Serial bit stream over cycles [first, first+15] packed MSB-first.
  function automatic logic [15:0] seq16(input logic [63:0] cap, input int first);
    logic [15:0] v = '0;
    for (int i = 0; i < 16; i++) v[15 - i] = cap[first + i];
    return v;
  endfunction

  task automatic chk_outs_reset(input string name);
    chk(name, 32'({SSPCLKOUT, SSPFSSOUT, SSPTXD, SSPOE_B, BUSY}), 32'(5'b00010));
  endtask

  logic [15:0] exp_a5, exp_3c, exp_c3, exp_ff;
  int          bad;

  initial begin
    exp_a5 = 16'b1100110000110011;
    exp_3c = 16'b0000111111110000;
    exp_c3 = 16'b1111000000001111;
    exp_ff = 16'hFFFF;
    CLEAR = 1'b1; SSE = 1'b0; valid_gate = 1'b0;
    drive();
    ticks(2);
    chk_en = 1'b1;
    chk_outs_reset("reset_outputs");
    CLEAR = 1'b0;
    drive();
    #1 chk("reset_nextword", 32'(NextWord), 32'(0));

    // Single word 0xA5.
    start_test();
    fifo.push_back(8'hA5); valid_gate = 1'b1; SSE = 1'b1; drive();
    ticks(20);
    chk("single_nw_count", 32'(nw_cyc.size()), 32'(1));
    chk("single_nw_cycle", 32'(nw_cyc[0]), 32'(0));
    chk("single_fss", 32'({cap_fss[1], cap_fss[2], cap_fss[3], cap_fss[19]}), 32'(4'b1100));
    chk("single_txd", 32'(seq16(cap_txd, 3)), 32'(exp_a5));
    chk("single_model_txd", 32'(seq16(mdl_txd, 3)), 32'(exp_a5));
    chk("single_oeb", 32'({cap_oeb[1], cap_oeb[18], cap_oeb[19]}), 32'(3'b001));
    chk("single_busy", 32'({cap_busy[1], cap_busy[18], cap_busy[19]}), 32'(3'b110));
    ticks(3);

    // Back-to-back 0x3C, 0xC3.
    start_test();
    fifo.push_back(8'h3C); fifo.push_back(8'hC3); drive();
    ticks(40);
    chk("b2b_nw_count", 32'(nw_cyc.size()), 32'(2));
    if (nw_cyc.size() == 2) chk("b2b_nw_second", 32'(nw_cyc[1]), 32'(18));
    chk("b2b_fss", 32'({cap_fss[1], cap_fss[2], cap_fss[3], cap_fss[18], cap_fss[19], cap_fss[20], cap_fss[21]}),
        32'(7'b1100110));
    bad = 0;
    for (int j = 1; j <= 36; j++) if (cap_clk[j] !== logic'(j % 2)) bad++;
    chk("b2b_clk_continuous", 32'(bad), 32'(0));
    chk("b2b_txd_first", 32'(seq16(cap_txd, 3)), 32'(exp_3c));
    chk("b2b_txd_second", 32'(seq16(cap_txd, 21)), 32'(exp_c3));
    chk("b2b_idle_c37", 32'({cap_busy[37], cap_oeb[37], cap_clk[37]}), 32'(3'b010));

    // Empty FIFO, then SSE gating.
    start_test();
    ticks(50);
    chk("empty_nw_count", 32'(nw_cyc.size()), 32'(0));
    chk_outs_reset("empty_outputs");
    SSE = 1'b0; fifo.push_back(8'h5A); drive();
    ticks(5);
    chk("sse_off_nw_count", 32'(nw_cyc.size()), 32'(0));
    SSE = 1'b1;
    #1 chk("sse_rise_nw", 32'(NextWord), 32'(1));
    tick();
    chk("sse_rise_frame", 32'({SSPFSSOUT, BUSY}), 32'(2'b11));
    ticks(20);

    // SSE dropped at c6 of a 0xFF frame.
    start_test();
    fifo.push_back(8'hFF); fifo.push_back(8'h55); drive();
    ticks(6);
    SSE = 1'b0; drive();
    ticks(16);
    chk("dis_nw_count", 32'(nw_cyc.size()), 32'(1));
    chk("dis_txd", 32'(seq16(cap_txd, 3)), 32'(exp_ff));
    chk("dis_idle_c19", 32'({cap_busy[19], cap_oeb[19]}), 32'(2'b01));
    fifo.delete(); drive();

    // CLEAR during bit 4 of a 0x81 frame.
    start_test();
    SSE = 1'b1; fifo.push_back(8'h81); drive();
    ticks(11);
    CLEAR = 1'b1; fifo.push_back(8'h5A); drive();
    #1 chk("clr_nw_low", 32'(NextWord), 32'(0));
    tick();
    chk_outs_reset("clr_outputs");
    chk("clr_nw_hold", 32'(NextWord), 32'(0));
    CLEAR = 1'b0; drive();
    #1 chk("clr_release_nw", 32'(NextWord), 32'(1));
    tick();
    chk("clr_new_frame", 32'({SSPFSSOUT, BUSY, SSPCLKOUT}), 32'(3'b111));
    ticks(20);

    // ValidWord arriving mid-frame.
    start_test();
    fifo.push_back(8'h96); drive();
    ticks(10);
    fifo.push_back(8'h69); drive();
    ticks(12);
    chk("late_nw_count", 32'(nw_cyc.size()), 32'(2));
    if (nw_cyc.size() == 2) chk("late_nw_second", 32'(nw_cyc[1]), 32'(18));
    chk("late_fss_c19", 32'({cap_fss[18], cap_fss[19]}), 32'(2'b01));
    ticks(20);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      SSE        = ($urandom_range(0, 15) != 0);
      valid_gate = ($urandom_range(0, 7) != 0);
      CLEAR      = ($urandom_range(0, 199) == 0);
      if (fifo.size() < 4 && $urandom_range(0, 3) == 0) fifo.push_back(W'($urandom));
      drive();
      tick();
    end
    CLEAR = 1'b0; valid_gate = 1'b0; drive();
    ticks(24);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
